uart_tx_serializer: RTL

//  UART transmit path: accepts a parallel word, launches an asynchronous serial frame on tx_out:

---
 rtl/uart_tx_serializer_pkg.sv | 23 ++
 rtl/uart_tx_serializer_if.sv | 21 ++
 rtl/uart_tx_serializer_serializer.sv | 27 ++
 rtl/uart_tx_serializer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and parity selection.
// The RX deserializer imports the same package so both sides agree on encodings.
package uart_tx_serializer_pkg;

    // Each state names the bit that the next tx_tick edge puts on the line.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // data_xor is the XOR-reduction of the data word; the result makes the total
    // count of ones even (PAR_EVEN) or odd (PAR_ODD).
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return data_xor ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Parallel-side request bundle of the UART transmitter plus its serial line and busy flag.
interface uart_tx_serializer_if #(
    parameter int DATA_SIZE = 8
);
    logic [DATA_SIZE-1:0] p_data;
    logic                 data_valid;
    logic                 par_en;
    logic                 par_typ;
    logic                 tx_out;
    logic                 busy;

    modport master (
        output p_data, data_valid, par_en, par_typ,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ,
        output tx_out, busy
    );
endinterface

// File: rtl/uart_tx_serializer_serializer.sv
// Parallel-load shift register presenting the word LSB first; mirror of the RX deserializer.
module uart_tx_serializer_serializer #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en_shift,
    input  logic [DATA_SIZE-1:0] p_data,
    output logic                 ser_out
);
    logic [DATA_SIZE-1:0] shift_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= p_data;
        end else if (en_shift) begin
            shift_q <= {1'b0, shift_q[DATA_SIZE-1:1]};
        end
    end

    assign ser_out = shift_q[0];

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_SIZE data bits LSB first, optional parity, STOP_BITS stop bits.
// Bit timing comes from tx_tick; acceptance of a new word ignores tx_tick.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_tick,
    uart_tx_serializer_if.slave  tx_if
);
    localparam int              CNT_W    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

    tx_state_t        state_q, state_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             load;
    logic             en_shift;
    logic             ser_out;

    uart_tx_serializer_serializer #(
        .DATA_SIZE(DATA_SIZE)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .en_shift (en_shift),
        .p_data   (tx_if.p_data),
        .ser_out  (ser_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
        end
    end

    // NOTE: every always_comb output is given a hold default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        load       = 1'b0;
        en_shift   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_if.data_valid) begin
                    load      = 1'b1;
                    par_en_d  = tx_if.par_en;
                    // Parity is fixed at acceptance from the same word the shifter loads.
                    par_bit_d = parity_bit(^tx_if.p_data, tx_if.par_typ);
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tx_tick) begin
                    tx_d       = 1'b0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    tx_d     = ser_out;
                    en_shift = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tx_tick) begin
                    tx_d    = par_bit_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_tick) begin
                    tx_d = 1'b1;
                    if (STOP_BITS == 1 || stop_cnt_q) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_if.tx_out = tx_q;
    assign tx_if.busy   = busy_q;

endmodule
